multi_sensor_fusion_system: RTL and testbench
=============================================

MULTI_SENSOR_FUSION_SYSTEM -- requirements
Module: multi_sensor_fusion_system

Interface
REQ-001 Parameters (name, default, meaning): CAMERA_WIDTH 3072 camera bits; LIDAR_WIDTH 512 lidar bits; RADAR_WIDTH 128 radar bits; IMU_WIDTH 64 IMU bits; FEATURE_WIDTH 256 feature bits (16 signed 16-bit lanes); OUTPUT_WIDTH 2048 output bits (128 lanes); FUSION_MIN_VAL -16384 clamp floor; FUSION_MAX_VAL 16383 clamp ceiling.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- clk in 1: clock.
- rst in 1: synchronous active-high reset.
- camera_bitstream in CAMERA_WIDTH; camera_valid in 1.
- lidar_compressed in LIDAR_WIDTH; lidar_valid in 1.
- radar_raw in RADAR_WIDTH; radar_valid in 1.
- imu_raw in IMU_WIDTH; imu_valid in 1.
- timestamp in 64: frame time.
- W_q, W_k, W_v in [6][16] x 16: signed per-token/lane attention weights.
- fc_weights in [128][96] x 16 signed; fc_bias in [128] x 16 signed.
- fused_tensor out OUTPUT_WIDTH; output_valid out 1; error_flags out 8.
- debug_camera_decoded CAMERA_WIDTH, debug_lidar_decoded LIDAR_WIDTH, debug_radar_filtered RADAR_WIDTH, debug_imu_synced IMU_WIDTH, debug_temporal_aligned 3840, debug_camera/lidar/radar_features FEATURE_WIDTH: all out.

Function
REQ-004 FSM states IDLE, FEAT, FC, DONE; frame accepted on an edge in IDLE with all four valids high and armed; inputs and timestamp captured at acceptance edge A.
REQ-005 Armed: set at reset and whenever camera_valid is sampled low; cleared on acceptance (no retrigger while valids stay high).
REQ-006 Error check at A: bit0 camera all-zero, bit1 lidar all-zero, bit2 radar all-zero, bit3 imu all-zero, bit4 timestamp <= previous accepted timestamp (not checked on first frame after reset); bits 7:5 = 0.
REQ-007 Error frame: skip FEAT/FC; at A+1 fused_tensor <= 0, error_flags <= flags, output_valid pulses one cycle.
REQ-008 Features: camera = XOR of twelve 256-bit slices; lidar = XOR of two 256-bit slices; radar = {radar,radar}; imu token = imu replicated 4x.
REQ-009 Tokens t0..t5 = camera, lidar, radar, imu, camera^lidar, lidar^radar features; lane j = bits [16j+:16], signed.
REQ-010 FEAT (A+1): for token t, lane j: q=(f*W_q[t][j])>>>8, k=(f*W_k[t][j])>>>8, v=(f*W_v[t][j])>>>8 (32-bit signed products); x[16t+j] = sat16(v) if sign(q)==sign(k) (zero counts non-negative), else 0.
REQ-011 FC: row i computed on edge A+2+i (i=0..127): acc = sum over j of fc_weights[i][j]*x[j] (40-bit signed); y = (acc>>>8) + fc_bias[i]; clamped to [FUSION_MIN_VAL, FUSION_MAX_VAL]; written to fused_tensor[16i+:16].
REQ-012 Good frame: output_valid pulses at edge A+130 for one cycle; error_flags <= 0 same edge.
REQ-013 fused_tensor and error_flags hold between frames; fused_tensor intermediate rows visible during FC.
REQ-014 Valids ignored outside IDLE; frame never aborted except by rst.
REQ-015 Debug: decoded/synced = captured inputs; debug_temporal_aligned = {camera, lidar, radar, imu, timestamp} captured; feature debugs = REQ-008 camera/lidar/radar features.

Reset
REQ-016 rst high at an edge: state IDLE, armed=1, first-frame flag set, all outputs, captured registers and previous timestamp to 0; rst mid-frame aborts with no output_valid.

Configuration
REQ-017 MSF_DEBUG_EN defined: debug outputs per REQ-015; undefined: all debug outputs tied 0, no debug registers; function otherwise identical.

Verification
REQ-018 Nonzero camera/lidar/radar/imu, increasing timestamp, random ±128 weights -> output_valid exactly 130 cycles after acceptance, error_flags=0, fused_tensor matches REQ-010/011 model.
REQ-019 camera_bitstream=0, others nonzero -> output_valid at A+1, error_flags=0x01, fused_tensor=0.
REQ-020 lidar_compressed=0 -> error_flags=0x02; subsequent good frame -> error_flags=0x00.
REQ-021 All fc_weights=0, fc_bias[i]=20000 -> every lane 16383; fc_bias[i]=-20000 -> every lane -16384.
REQ-022 Valids held high after output_valid -> no second frame until camera_valid low one cycle; rst asserted at A+50 -> no output_valid, outputs 0.
REQ-023 Second frame with timestamp equal to first -> error_flags=0x10.

Source files
------------

// File: rtl/multi_sensor_fusion_system.sv
// Sensor fusion pipeline: slice-XOR feature extraction, gated per-lane attention, then one FC row per cycle.
// Define MSF_DEBUG_EN to expose the captured inputs and features on the debug ports; otherwise they read 0.
module multi_sensor_fusion_system #(
  parameter int CAMERA_WIDTH   = 3072,
  parameter int LIDAR_WIDTH    = 512,
  parameter int RADAR_WIDTH    = 128,
  parameter int IMU_WIDTH      = 64,
  parameter int FEATURE_WIDTH  = 256,
  parameter int OUTPUT_WIDTH   = 2048,
  parameter int FUSION_MIN_VAL = -16384,
  parameter int FUSION_MAX_VAL = 16383
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CAMERA_WIDTH-1:0]    camera_bitstream,
  input  logic                       camera_valid,
  input  logic [LIDAR_WIDTH-1:0]     lidar_compressed,
  input  logic                       lidar_valid,
  input  logic [RADAR_WIDTH-1:0]     radar_raw,
  input  logic                       radar_valid,
  input  logic [IMU_WIDTH-1:0]       imu_raw,
  input  logic                       imu_valid,
  input  logic [63:0]                timestamp,
  input  logic signed [15:0]         W_q [6][16],
  input  logic signed [15:0]         W_k [6][16],
  input  logic signed [15:0]         W_v [6][16],
  input  logic signed [15:0]         fc_weights [128][96],
  input  logic signed [15:0]         fc_bias [128],
  output logic [OUTPUT_WIDTH-1:0]    fused_tensor,
  output logic                       output_valid,
  output logic [7:0]                 error_flags,
  output logic [CAMERA_WIDTH-1:0]    debug_camera_decoded,
  output logic [LIDAR_WIDTH-1:0]     debug_lidar_decoded,
  output logic [RADAR_WIDTH-1:0]     debug_radar_filtered,
  output logic [IMU_WIDTH-1:0]       debug_imu_synced,
  output logic [3839:0]              debug_temporal_aligned,
  output logic [FEATURE_WIDTH-1:0]   debug_camera_features,
  output logic [FEATURE_WIDTH-1:0]   debug_lidar_features,
  output logic [FEATURE_WIDTH-1:0]   debug_radar_features
);
  localparam int NTOK  = 6;
  localparam int NLANE = 16;
  localparam int NX    = NTOK * NLANE;

  typedef enum logic [1:0] {IDLE, FEAT, FC, DONE} state_t;
  state_t state_reg, state_next;

  logic                     armed_reg, first_reg;
  logic [63:0]              prev_ts_reg;
  logic [7:0]               err_reg, err_next;
  logic [6:0]               row_reg;
  logic [FEATURE_WIDTH-1:0] cam_feat_reg, lidar_feat_reg, cam_feat_next, lidar_feat_next;
  logic [RADAR_WIDTH-1:0]   radar_reg;
  logic [IMU_WIDTH-1:0]     imu_reg;
  logic [FEATURE_WIDTH-1:0] tok [NTOK];
  logic signed [15:0]       x_reg [NX];
  logic signed [15:0]       x_next [NX];
  logic signed [39:0]       acc, y;
  logic [15:0]              y16;
  logic                     accept;

  assign accept = (state_reg == IDLE) && camera_valid && lidar_valid && radar_valid
                  && imu_valid && armed_reg;

  always_comb begin
    cam_feat_next = '0;
    for (int s = 0; s < CAMERA_WIDTH / FEATURE_WIDTH; s++)
      cam_feat_next = cam_feat_next ^ camera_bitstream[s*FEATURE_WIDTH +: FEATURE_WIDTH];
    lidar_feat_next = '0;
    for (int s = 0; s < LIDAR_WIDTH / FEATURE_WIDTH; s++)
      lidar_feat_next = lidar_feat_next ^ lidar_compressed[s*FEATURE_WIDTH +: FEATURE_WIDTH];
  end

  // The timestamp ordering check is suppressed until one frame has been accepted since reset.
  always_comb begin
    err_next    = '0;
    err_next[0] = ~|camera_bitstream;
    err_next[1] = ~|lidar_compressed;
    err_next[2] = ~|radar_raw;
    err_next[3] = ~|imu_raw;
    err_next[4] = !first_reg && (timestamp <= prev_ts_reg);
  end

  always_comb begin
    tok[0] = cam_feat_reg;
    tok[1] = lidar_feat_reg;
    tok[2] = {radar_reg, radar_reg};
    tok[3] = {4{imu_reg}};
    tok[4] = cam_feat_reg ^ lidar_feat_reg;
    tok[5] = lidar_feat_reg ^ {radar_reg, radar_reg};
  end

  // Attention lane: value passes through only when query and key agree in sign.
  genvar gi;
  generate
    for (gi = 0; gi < NX; gi++) begin : g_lane
      localparam int T = gi / NLANE;
      localparam int J = gi % NLANE;
      logic signed [15:0] f, v_sat;
      logic signed [31:0] q, k, v;
      assign f = tok[T][16*J +: 16];
      assign q = (32'(f) * 32'(W_q[T][J])) >>> 8;
      assign k = (32'(f) * 32'(W_k[T][J])) >>> 8;
      assign v = (32'(f) * 32'(W_v[T][J])) >>> 8;
      assign v_sat = (v > 32'sd32767) ? 16'sh7fff :
                     (v < -32'sd32768) ? 16'sh8000 : v[15:0];
      assign x_next[gi] = (q[31] == k[31]) ? v_sat : 16'sd0;
    end
  endgenerate

  always_comb begin
    acc = '0;
    for (int j = 0; j < NX; j++)
      acc = acc + 40'(fc_weights[row_reg][j]) * 40'(x_reg[j]);
    y = (acc >>> 8) + 40'(fc_bias[row_reg]);
    if (y > 40'(FUSION_MAX_VAL))      y16 = 16'(FUSION_MAX_VAL);
    else if (y < 40'(FUSION_MIN_VAL)) y16 = 16'(FUSION_MIN_VAL);
    else                              y16 = y[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = (|err_next) ? DONE : FEAT;
      FEAT: state_next = FC;
      FC:   if (row_reg == 7'd127) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_reg      <= 1'b1;
      first_reg      <= 1'b1;
      prev_ts_reg    <= '0;
      err_reg        <= '0;
      row_reg        <= '0;
      cam_feat_reg   <= '0;
      lidar_feat_reg <= '0;
      radar_reg      <= '0;
      imu_reg        <= '0;
      fused_tensor   <= '0;
      output_valid   <= 1'b0;
      error_flags    <= '0;
      for (int i = 0; i < NX; i++) x_reg[i] <= '0;
    end else begin
      output_valid <= 1'b0;
      if (!camera_valid) armed_reg <= 1'b1;
      if (accept) begin
        armed_reg      <= 1'b0;
        first_reg      <= 1'b0;
        prev_ts_reg    <= timestamp;
        err_reg        <= err_next;
        row_reg        <= '0;
        cam_feat_reg   <= cam_feat_next;
        lidar_feat_reg <= lidar_feat_next;
        radar_reg      <= radar_raw;
        imu_reg        <= imu_raw;
      end
      case (state_reg)
        FEAT: for (int i = 0; i < NX; i++) x_reg[i] <= x_next[i];
        FC: begin
          fused_tensor[{row_reg, 4'b0000} +: 16] <= y16;
          row_reg <= row_reg + 7'd1;
        end
        DONE: begin
          output_valid <= 1'b1;
          error_flags  <= err_reg;
          if (|err_reg) fused_tensor <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef MSF_DEBUG_EN
  logic [CAMERA_WIDTH-1:0] cam_dbg_reg;
  logic [LIDAR_WIDTH-1:0]  lidar_dbg_reg;
  logic [63:0]             ts_dbg_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cam_dbg_reg   <= '0;
      lidar_dbg_reg <= '0;
      ts_dbg_reg    <= '0;
    end else if (accept) begin
      cam_dbg_reg   <= camera_bitstream;
      lidar_dbg_reg <= lidar_compressed;
      ts_dbg_reg    <= timestamp;
    end
  end

  assign debug_camera_decoded   = cam_dbg_reg;
  assign debug_lidar_decoded    = lidar_dbg_reg;
  assign debug_radar_filtered   = radar_reg;
  assign debug_imu_synced       = imu_reg;
  assign debug_temporal_aligned = {cam_dbg_reg, lidar_dbg_reg, radar_reg, imu_reg, ts_dbg_reg};
  assign debug_camera_features  = cam_feat_reg;
  assign debug_lidar_features   = lidar_feat_reg;
  assign debug_radar_features   = {radar_reg, radar_reg};
`else
  assign debug_camera_decoded   = '0;
  assign debug_lidar_decoded    = '0;
  assign debug_radar_filtered   = '0;
  assign debug_imu_synced       = '0;
  assign debug_temporal_aligned = '0;
  assign debug_camera_features  = '0;
  assign debug_lidar_features   = '0;
  assign debug_radar_features   = '0;
`endif

endmodule

// File: tb/tb_multi_sensor_fusion_system.sv
// Self-checking bench for multi_sensor_fusion_system: random frames against an arithmetic model.
module tb_multi_sensor_fusion_system;
  logic clk = 1'b0;
  logic rst;
  logic [3071:0] camera;
  logic [511:0]  lidar;
  logic [127:0]  radar;
  logic [63:0]   imu;
  logic          cam_v, lid_v, rad_v, imu_v;
  logic [63:0]   ts;
  logic signed [15:0] wq [6][16];
  logic signed [15:0] wk [6][16];
  logic signed [15:0] wv [6][16];
  logic signed [15:0] fc_w [128][96];
  logic signed [15:0] fc_b [128];
  logic [2047:0] fused_tensor;
  logic          output_valid;
  logic [7:0]    error_flags;
  logic [3071:0] dbg_cam;
  logic [511:0]  dbg_lid;
  logic [127:0]  dbg_rad;
  logic [63:0]   dbg_imu;
  logic [3839:0] dbg_tmp;
  logic [255:0]  dbg_cf, dbg_lf, dbg_rf;

  int checks = 0;
  int fails  = 0;
  int exp_lane [128];

  multi_sensor_fusion_system dut (
    .clk(clk), .rst(rst),
    .camera_bitstream(camera), .camera_valid(cam_v),
    .lidar_compressed(lidar), .lidar_valid(lid_v),
    .radar_raw(radar), .radar_valid(rad_v),
    .imu_raw(imu), .imu_valid(imu_v),
    .timestamp(ts),
    .W_q(wq), .W_k(wk), .W_v(wv),
    .fc_weights(fc_w), .fc_bias(fc_b),
    .fused_tensor(fused_tensor), .output_valid(output_valid), .error_flags(error_flags),
    .debug_camera_decoded(dbg_cam), .debug_lidar_decoded(dbg_lid),
    .debug_radar_filtered(dbg_rad), .debug_imu_synced(dbg_imu),
    .debug_temporal_aligned(dbg_tmp),
    .debug_camera_features(dbg_cf), .debug_lidar_features(dbg_lf),
    .debug_radar_features(dbg_rf)
  );

  always #5 clk = ~clk;

  function automatic logic signed [15:0] rnd_w();
    int r;
    r = int'($urandom_range(0, 256)) - 128;
    return 16'(r);
  endfunction

  task automatic randomize_weights();
    for (int t = 0; t < 6; t++)
      for (int j = 0; j < 16; j++) begin
        wq[t][j] = rnd_w(); wk[t][j] = rnd_w(); wv[t][j] = rnd_w();
      end
    for (int i = 0; i < 128; i++) begin
      fc_b[i] = rnd_w();
      for (int j = 0; j < 96; j++) fc_w[i][j] = rnd_w();
    end
  endtask

  task automatic randomize_sensors();
    for (int i = 0; i < 96; i++) camera[32*i +: 32] = $urandom;
    for (int i = 0; i < 16; i++) lidar[32*i +: 32] = $urandom;
    for (int i = 0; i < 4; i++)  radar[32*i +: 32] = $urandom;
    imu = {$urandom, $urandom};
    camera[0] = 1'b1; lidar[300] = 1'b1; radar[5] = 1'b1; imu[63] = 1'b1;
  endtask

  // Reference: features -> six tokens -> gated attention values -> FC with clamp.
  task automatic compute_model();
    logic [255:0] cf, lf, rf, imf;
    logic [255:0] tk [6];
    logic signed [15:0] lane;
    int f, q, k, v;
    int xm [96];
    longint acc, y;
    cf = '0;
    for (int s = 0; s < 12; s++) cf = cf ^ camera[256*s +: 256];
    lf  = lidar[255:0] ^ lidar[511:256];
    rf  = {radar, radar};
    imf = {imu, imu, imu, imu};
    tk[0] = cf; tk[1] = lf; tk[2] = rf; tk[3] = imf; tk[4] = cf ^ lf; tk[5] = lf ^ rf;
    for (int t = 0; t < 6; t++)
      for (int j = 0; j < 16; j++) begin
        lane = tk[t][16*j +: 16];
        f = lane;
        q = (f * int'(wq[t][j])) >>> 8;
        k = (f * int'(wk[t][j])) >>> 8;
        v = (f * int'(wv[t][j])) >>> 8;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        xm[16*t + j] = ((q < 0) == (k < 0)) ? v : 0;
      end
    for (int i = 0; i < 128; i++) begin
      acc = 0;
      for (int j = 0; j < 96; j++) acc += longint'(fc_w[i][j]) * longint'(xm[j]);
      y = (acc >>> 8) + longint'(fc_b[i]);
      if (y > 16383) y = 16383;
      if (y < -16384) y = -16384;
      exp_lane[i] = int'(y);
    end
  endtask

  // Presents a frame and returns cycles from acceptance edge to output_valid (-1 on timeout).
  task automatic send_frame(input bit keep, output int lat);
    cam_v = 1'b1; lid_v = 1'b1; rad_v = 1'b1; imu_v = 1'b1;
    @(posedge clk); #1;
    if (!keep) begin
      cam_v = 1'b0; lid_v = 1'b0; rad_v = 1'b0; imu_v = 1'b0;
    end
    lat = -1;
    for (int n = 1; n <= 200 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (output_valid) lat = n;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (output_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", output_valid); end
    checks++;
    if (error_flags !== 8'h00) begin fails++; $display("FAIL reset_flags got %h want 00", error_flags); end
    checks++;
    if (fused_tensor !== '0) begin fails++; $display("FAIL reset_tensor got nonzero want 0"); end
    checks++;
    if (dbg_tmp !== '0) begin fails++; $display("FAIL reset_debug got nonzero want 0"); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame(input int idx);
    int lat;
    randomize_weights();
    randomize_sensors();
    ts = ts + 64'(1 + $urandom_range(0, 50));
    compute_model();
    send_frame(1'b0, lat);
    $display("good frame %0d: latency %0d flags %h", idx, lat, error_flags);
    checks++;
    if (lat != 130) begin fails++; $display("FAIL good_latency got %0d want 130", lat); end
    checks++;
    if (error_flags !== 8'h00) begin fails++; $display("FAIL good_flags got %h want 00", error_flags); end
    for (int i = 0; i < 128; i++) begin
      checks++;
      if ($signed(fused_tensor[16*i +: 16]) != exp_lane[i]) begin
        fails++;
        $display("FAIL good_lane%0d got %0d want %0d", i, $signed(fused_tensor[16*i +: 16]), exp_lane[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (output_valid !== 1'b0) begin fails++; $display("FAIL good_pulse_width got %b want 0", output_valid); end
  endtask

  task automatic test_camera_zero();
    int lat;
    randomize_sensors();
    camera = '0;
    ts = ts + 64'd10;
    send_frame(1'b0, lat);
    $display("camera-zero frame: latency %0d flags %h", lat, error_flags);
    checks++;
    if (lat != 1) begin fails++; $display("FAIL camzero_latency got %0d want 1", lat); end
    checks++;
    if (error_flags !== 8'h01) begin fails++; $display("FAIL camzero_flags got %h want 01", error_flags); end
    checks++;
    if (fused_tensor !== '0) begin fails++; $display("FAIL camzero_tensor got nonzero want 0"); end
  endtask

  task automatic test_lidar_zero_then_good();
    int lat;
    randomize_sensors();
    lidar = '0;
    ts = ts + 64'd10;
    send_frame(1'b0, lat);
    $display("lidar-zero frame: latency %0d flags %h", lat, error_flags);
    checks++;
    if (lat != 1 || error_flags !== 8'h02) begin
      fails++; $display("FAIL lidzero got latency %0d flags %h want 1/02", lat, error_flags);
    end
    test_good_frame(99);
  endtask

  task automatic test_ts_equal();
    int lat;
    randomize_sensors();
    ts = ts + 64'd5;
    send_frame(1'b0, lat);
    checks++;
    if (lat != 130 || error_flags !== 8'h00) begin
      fails++; $display("FAIL ts_first got latency %0d flags %h want 130/00", lat, error_flags);
    end
    randomize_sensors();
    send_frame(1'b0, lat);
    $display("equal-timestamp frame: latency %0d flags %h", lat, error_flags);
    checks++;
    if (lat != 1 || error_flags !== 8'h10) begin
      fails++; $display("FAIL ts_equal got latency %0d flags %h want 1/10", lat, error_flags);
    end
    checks++;
    if (fused_tensor !== '0) begin fails++; $display("FAIL ts_equal_tensor got nonzero want 0"); end
  endtask

  task automatic test_saturation();
    int lat;
    for (int s = 0; s < 2; s++) begin
      int want;
      int bad;
      want = (s == 0) ? 16383 : -16384;
      for (int i = 0; i < 128; i++) begin
        fc_b[i] = (s == 0) ? 16'sd20000 : -16'sd20000;
        for (int j = 0; j < 96; j++) fc_w[i][j] = 16'sd0;
      end
      randomize_sensors();
      ts = ts + 64'd3;
      send_frame(1'b0, lat);
      bad = 0;
      for (int i = 0; i < 128; i++)
        if ($signed(fused_tensor[16*i +: 16]) != want) bad++;
      $display("saturation frame bias %0d: latency %0d bad lanes %0d", fc_b[0], lat, bad);
      checks++;
      if (lat != 130) begin fails++; $display("FAIL sat_latency got %0d want 130", lat); end
      checks++;
      if (bad != 0) begin
        fails++;
        $display("FAIL sat_lanes got lane0 %0d want %0d (%0d lanes off)", $signed(fused_tensor[15:0]), want, bad);
      end
    end
  endtask

  task automatic test_rearm_and_reset();
    int lat;
    int pulses;
    randomize_weights();
    randomize_sensors();
    ts = ts + 64'd7;
    send_frame(1'b1, lat);
    checks++;
    if (lat != 130) begin fails++; $display("FAIL hold_first got %0d want 130", lat); end
    pulses = 0;
    for (int n = 0; n < 150; n++) begin
      @(posedge clk); #1;
      if (output_valid) pulses++;
    end
    $display("held valids: %0d extra output pulses", pulses);
    checks++;
    if (pulses != 0) begin fails++; $display("FAIL hold_retrigger got %0d pulses want 0", pulses); end
    cam_v = 1'b0;
    @(posedge clk); #1;
    ts = ts + 64'd7;
    compute_model();
    send_frame(1'b0, lat);
    $display("rearmed frame: latency %0d", lat);
    checks++;
    if (lat != 130) begin fails++; $display("FAIL rearm_latency got %0d want 130", lat); end
    checks++;
    if ($signed(fused_tensor[16*77 +: 16]) != exp_lane[77]) begin
      fails++; $display("FAIL rearm_lane77 got %0d want %0d", $signed(fused_tensor[16*77 +: 16]), exp_lane[77]);
    end
    // Abort a frame with reset 50 edges after acceptance.
    randomize_sensors();
    ts = ts + 64'd7;
    cam_v = 1'b1; lid_v = 1'b1; rad_v = 1'b1; imu_v = 1'b1;
    @(posedge clk); #1;
    cam_v = 1'b0; lid_v = 1'b0; rad_v = 1'b0; imu_v = 1'b0;
    pulses = 0;
    for (int n = 1; n < 50; n++) begin
      @(posedge clk); #1;
      if (output_valid) pulses++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (output_valid) pulses++;
    end
    $display("aborted frame: %0d output pulses, flags %h", pulses, error_flags);
    checks++;
    if (pulses != 0) begin fails++; $display("FAIL abort_pulses got %0d want 0", pulses); end
    checks++;
    if (fused_tensor !== '0 || error_flags !== 8'h00) begin
      fails++; $display("FAIL abort_outputs got flags %h tensor nonzero=%b want 0", error_flags, |fused_tensor);
    end
    // First frame after reset with a small timestamp must not be flagged.
    ts = 64'd1;
    compute_model();
    send_frame(1'b0, lat);
    $display("post-reset frame: latency %0d flags %h", lat, error_flags);
    checks++;
    if (lat != 130 || error_flags !== 8'h00) begin
      fails++; $display("FAIL post_reset got latency %0d flags %h want 130/00", lat, error_flags);
    end
  endtask

  initial begin
    rst = 1'b1;
    camera = '0; lidar = '0; radar = '0; imu = '0;
    cam_v = 1'b0; lid_v = 1'b0; rad_v = 1'b0; imu_v = 1'b0;
    ts = 64'd1000;
    for (int i = 0; i < 128; i++) begin
      fc_b[i] = '0;
      for (int j = 0; j < 96; j++) fc_w[i][j] = '0;
    end
    for (int t = 0; t < 6; t++)
      for (int j = 0; j < 16; j++) begin
        wq[t][j] = '0; wk[t][j] = '0; wv[t][j] = '0;
      end
    test_reset();
    test_good_frame(0);
    test_good_frame(1);
    test_good_frame(2);
    test_camera_zero();
    test_lidar_zero_then_good();
    test_ts_equal();
    test_saturation();
    test_rearm_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
